// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: SPI slave receiver feeding a word FIFO.
// sck, sda, cs_n and dc are brought into the clk domain through 2-flop
// synchronizers; words are assembled in a shift register and pushed, together
// with their dc flag, into a FIFO that the host drains with rd_en.
// Optional build macro: SPI_RX_OVERFLOW_COUNT_EN adds the 8-bit saturating
// overflow_count output (count of dropped words).
module spi_rx_fifo #(
  parameter int BITS              = 8,
  parameter int FIFO_DEPTH        = 32,
  parameter int ALMOST_FULL_RANGE = 2,
  parameter int CPOL              = 0,
  parameter int CPHA              = 0,
  parameter int LSB_FIRST         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sck,
  input  logic                        sda,
  input  logic                        cs_n,
  input  logic                        dc,
  input  logic                        rd_en,
  output logic [BITS-1:0]             rd_data,
  output logic                        rd_dc,
  output logic                        rd_valid,
  output logic                        fifo_empty,
  output logic                        fifo_almost_full,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
`ifdef SPI_RX_OVERFLOW_COUNT_EN
  ,
  output logic [7:0]                  overflow_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(BITS);
  localparam int AF_THRESH = FIFO_DEPTH - ALMOST_FULL_RANGE;
  localparam bit SAMPLE_RISING = (CPOL == CPHA);
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

  // Synchronizer stages, packed as {dc, cs_n, sda, sck}
  logic [3:0] syncMeta_q;
  logic [3:0] syncOut_q;
  logic       sckPrev_q;

  logic sckSync, sdaSync, csSync, dcSync;
  logic sckRise, sckFall, sampleEdge;

  // Receiver state
  logic            armed_q;
  logic [BITS-1:0] shift_q;
  logic [BITS-1:0] shiftNext;
  logic [CW-1:0]   bitCount_q;
  logic            pushValid_q;
  logic [BITS-1:0] pushData_q;
  logic            pushDc_q;

  // FIFO state
  logic [BITS:0]   mem_q [FIFO_DEPTH];
  logic [BITS:0]   memRd;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, levelD;
  logic            fifoEmpty_q, fifoFull_q, almostFull_q;
  logic [BITS-1:0] rdData_q;
  logic            rdDc_q, rdValid_q, overflow_q;
  logic            doPop, doPush, doDrop;

  assign sckSync = syncOut_q[0];
  assign sdaSync = syncOut_q[1];
  assign csSync  = syncOut_q[2];
  assign dcSync  = syncOut_q[3];

  assign sckRise    = sckSync & ~sckPrev_q;
  assign sckFall    = ~sckSync & sckPrev_q;
  assign sampleEdge = SAMPLE_RISING ? sckRise : sckFall;

  assign shiftNext = (LSB_FIRST != 0) ? {sdaSync, shift_q[BITS-1:1]}
                                      : {shift_q[BITS-2:0], sdaSync};

  assign memRd = mem_q[rptr_q];

  // Two-flop synchronizers for all SPI pins plus the sck edge-detect register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
      sckPrev_q  <= 1'b0;
    end else begin
      syncMeta_q <= {dc, cs_n, sda, sck};
      syncOut_q  <= syncMeta_q;
      sckPrev_q  <= syncOut_q[0];
    end
  end

  // Word assembly; armed_q keeps a frame cut by reset from resuming until cs_n has been seen high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q     <= 1'b0;
      shift_q     <= '0;
      bitCount_q  <= '0;
      pushValid_q <= 1'b0;
      pushData_q  <= '0;
      pushDc_q    <= 1'b0;
    end else begin
      pushValid_q <= 1'b0;
      if (csSync) begin
        armed_q    <= 1'b1;
        shift_q    <= '0;
        bitCount_q <= '0;
      end else if (armed_q && sampleEdge) begin
        shift_q <= shiftNext;
        if (bitCount_q == LAST_BIT) begin
          bitCount_q  <= '0;
          pushValid_q <= 1'b1;
          pushData_q  <= shiftNext;
          pushDc_q    <= dcSync;
        end else begin
          bitCount_q <= bitCount_q + CW'(1);
        end
      end
    end
  end

  // FIFO control: a pop frees the slot a same-cycle push needs, so push+pop works even when full
  always_comb begin
    doPop  = rd_en && !fifoEmpty_q;
    doPush = pushValid_q && (!fifoFull_q || doPop);
    doDrop = pushValid_q && fifoFull_q && !doPop;
    levelD = level_q;
    if (doPush && !doPop) begin
      levelD = level_q + LW'(1);
    end else if (doPop && !doPush) begin
      levelD = level_q - LW'(1);
    end
  end

  // FIFO pointers, occupancy, registered status flags and the registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      fifoEmpty_q  <= 1'b1;
      fifoFull_q   <= 1'b0;
      almostFull_q <= 1'b0;
      rdData_q     <= '0;
      rdDc_q       <= 1'b0;
      rdValid_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      level_q      <= levelD;
      fifoEmpty_q  <= (levelD == '0);
      fifoFull_q   <= (levelD == LW'(FIFO_DEPTH));
      almostFull_q <= (int'(levelD) >= AF_THRESH);
      rdValid_q    <= doPop;
      if (doPop) begin
        rdData_q <= memRd[BITS-1:0];
        rdDc_q   <= memRd[BITS];
        rptr_q   <= rptr_q + PW'(1);
      end
      if (doPush) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (doDrop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage array; left out of reset since occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wptr_q] <= {pushDc_q, pushData_q};
    end
  end

`ifdef SPI_RX_OVERFLOW_COUNT_EN
  logic [7:0] ovfCount_q;

  // Saturating count of words dropped because the FIFO was full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfCount_q <= 8'd0;
    end else if (doDrop && (ovfCount_q != 8'hFF)) begin
      ovfCount_q <= ovfCount_q + 8'd1;
    end
  end

  assign overflow_count = ovfCount_q;
`endif

  assign rd_data          = rdData_q;
  assign rd_dc            = rdDc_q;
  assign rd_valid         = rdValid_q;
  assign fifo_empty       = fifoEmpty_q;
  assign fifo_almost_full = almostFull_q;
  assign fifo_full        = fifoFull_q;
  assign level            = level_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed bench for spi_rx_fifo.
// Three instances share clk/rst/sda/dc: u0 defaults (mode 0, MSB first),
// u1 mode 3 LSB first, u2 mode 0 with a 4-entry FIFO.
// Honours SPI_RX_OVERFLOW_COUNT_EN to connect and check overflow_count.
module tb_spi_rx_fifo;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] sck, csN, rdEn;
  logic sda, dc;

  logic [7:0] rdData0, rdData1, rdData2;
  logic       rdDc0, rdDc1, rdDc2;
  logic       rdValid0, rdValid1, rdValid2;
  logic       empty0, empty1, empty2;
  logic       afull0, afull1, afull2;
  logic       full0, full1, full2;
  logic       ovf0, ovf1, ovf2;
  logic [5:0] level0, level1;
  logic [2:0] level2;
`ifdef SPI_RX_OVERFLOW_COUNT_EN
  logic [7:0] ovfCnt0, ovfCnt1, ovfCnt2;
`endif

  int nCompared = 0;
  int nMismatch = 0;

  typedef struct {
    logic [7:0] word;
    logic       dcBit;
    logic [7:0] expData;
    logic       expDc;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] words37 [6];
  logic [8:0] model [$];
  logic [8:0] expWord;
  logic [7:0] w;
  logic       dcb;

  // 100 MHz system clock; SPI bit period is 8 clk cycles
  always #5 clk = ~clk;

  spi_rx_fifo u0 (
    .clk(clk), .rst(rst), .sck(sck[0]), .sda(sda), .cs_n(csN[0]), .dc(dc),
    .rd_en(rdEn[0]), .rd_data(rdData0), .rd_dc(rdDc0), .rd_valid(rdValid0),
    .fifo_empty(empty0), .fifo_almost_full(afull0), .fifo_full(full0),
    .level(level0), .overflow(ovf0)
`ifdef SPI_RX_OVERFLOW_COUNT_EN
    , .overflow_count(ovfCnt0)
`endif
  );

  spi_rx_fifo #(.CPOL(1), .CPHA(1), .LSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .sck(sck[1]), .sda(sda), .cs_n(csN[1]), .dc(dc),
    .rd_en(rdEn[1]), .rd_data(rdData1), .rd_dc(rdDc1), .rd_valid(rdValid1),
    .fifo_empty(empty1), .fifo_almost_full(afull1), .fifo_full(full1),
    .level(level1), .overflow(ovf1)
`ifdef SPI_RX_OVERFLOW_COUNT_EN
    , .overflow_count(ovfCnt1)
`endif
  );

  spi_rx_fifo #(.FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .sck(sck[2]), .sda(sda), .cs_n(csN[2]), .dc(dc),
    .rd_en(rdEn[2]), .rd_data(rdData2), .rd_dc(rdDc2), .rd_valid(rdValid2),
    .fifo_empty(empty2), .fifo_almost_full(afull2), .fifo_full(full2),
    .level(level2), .overflow(ovf2)
`ifdef SPI_RX_OVERFLOW_COUNT_EN
    , .overflow_count(ovfCnt2)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Shift nbits of w into instance u; data set up while sck low, sampled on the rise
  task automatic applyStimulus(input int u, input logic [7:0] wd, input logic dcBit,
                               input int nbits, input bit lsbFirst);
    for (int i = 0; i < nbits; i++) begin
      sck[u] = 1'b0;
      sda    = lsbFirst ? wd[i] : wd[7-i];
      dc     = dcBit;
      tick(4);
      sck[u] = 1'b1;
      tick(4);
    end
    if (u != 1) sck[u] = 1'b0;
  endtask

  task automatic frameStart(input int u);
    csN[u] = 1'b0;
    tick(4);
  endtask

  task automatic frameEnd(input int u);
    csN[u] = 1'b1;
    tick(4);
  endtask

  task automatic popWord(input int u);
    rdEn[u] = 1'b1;
    tick(1);
    rdEn[u] = 1'b0;
  endtask

  // Directed sequence: reset, latency, vector table, then multi-cycle corners
  initial begin
    vecs[0] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 8'h81, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
    vecs[5] = '{8'h96, 1'b1, 8'h96, 1'b1};
    words37 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst = 1'b1; csN = 3'b111; sck = 3'b010; rdEn = 3'b000; sda = 1'b0; dc = 1'b0;
    tick(3);
    checkOutput("reset_empty", 32'(empty0), 1);
    checkOutput("reset_level", 32'(level0), 0);
    checkOutput("reset_full", 32'(full0), 0);
    checkOutput("reset_afull", 32'(afull0), 0);
    checkOutput("reset_valid", 32'(rdValid0), 0);
    checkOutput("reset_ovf", 32'(ovf2), 0);
    rst = 1'b0;
    tick(4);

    // Mode 0 latency: 0xA5 dc=1, level rises exactly 4 clk after the 8th rise
    frameStart(0);
    applyStimulus(0, 8'hA5, 1'b1, 7, 1'b0);
    sda = 1'b1; dc = 1'b1;
    tick(4);
    sck[0] = 1'b1;
    tick(3);
    checkOutput("lat_level_at3", 32'(level0), 0);
    checkOutput("lat_empty_at3", 32'(empty0), 1);
    tick(1);
    checkOutput("lat_level_at4", 32'(level0), 1);
    checkOutput("lat_empty_at4", 32'(empty0), 0);
    sck[0] = 1'b0;
    tick(4);
    popWord(0);
    checkOutput("a5_data", 32'(rdData0), 'hA5);
    checkOutput("a5_dc", 32'(rdDc0), 1);
    checkOutput("a5_valid", 32'(rdValid0), 1);
    tick(1);
    checkOutput("a5_valid_drop", 32'(rdValid0), 0);
    checkOutput("a5_empty", 32'(empty0), 1);

    // Back-to-back words inside one frame
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, vecs[k].word, vecs[k].dcBit, 8, 1'b0);
      tick(1);
      checkOutput("vec_level", 32'(level0), 1);
      popWord(0);
      checkOutput("vec_data", 32'(rdData0), 32'(vecs[k].expData));
      checkOutput("vec_dc", 32'(rdDc0), 32'(vecs[k].expDc));
      checkOutput("vec_valid", 32'(rdValid0), 1);
    end
    frameEnd(0);

    // Partial word discarded when cs_n rises
    frameStart(0);
    applyStimulus(0, 8'hE7, 1'b1, 5, 1'b0);
    frameEnd(0);
    frameStart(0);
    applyStimulus(0, 8'h3C, 1'b0, 8, 1'b0);
    tick(2);
    checkOutput("partial_level", 32'(level0), 1);
    popWord(0);
    checkOutput("partial_data", 32'(rdData0), 'h3C);
    checkOutput("partial_dc", 32'(rdDc0), 0);
    tick(1);
    checkOutput("partial_empty", 32'(empty0), 1);
    frameEnd(0);

    // Mode 3, LSB first
    frameStart(1);
    applyStimulus(1, 8'h01, 1'b0, 8, 1'b1);
    tick(1);
    checkOutput("m3_level", 32'(level1), 1);
    popWord(1);
    checkOutput("m3_data01", 32'(rdData1), 'h01);
    checkOutput("m3_dc01", 32'(rdDc1), 0);
    applyStimulus(1, 8'hB4, 1'b1, 8, 1'b1);
    popWord(1);
    checkOutput("m3_dataB4", 32'(rdData1), 'hB4);
    checkOutput("m3_dcB4", 32'(rdDc1), 1);
    frameEnd(1);

    // Depth 4: six words with no reads, two are dropped
    frameStart(2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2, words37[i], 1'(i % 2), 8, 1'b0);
      checkOutput("ovf_level", 32'(level2), (i < 4) ? i + 1 : 4);
      checkOutput("ovf_full", 32'(full2), (i >= 3) ? 1 : 0);
      checkOutput("ovf_afull", 32'(afull2), (i >= 1) ? 1 : 0);
      checkOutput("ovf_flag", 32'(ovf2), (i >= 4) ? 1 : 0);
    end
`ifdef SPI_RX_OVERFLOW_COUNT_EN
    checkOutput("ovf_count", 32'(ovfCnt2), 2);
`endif
    for (int i = 0; i < 4; i++) begin
      popWord(2);
      checkOutput("ovf_rd_data", 32'(rdData2), 32'(words37[i]));
      checkOutput("ovf_rd_dc", 32'(rdDc2), i % 2);
    end
    tick(1);
    checkOutput("ovf_drained", 32'(empty2), 1);
    popWord(2);
    checkOutput("empty_pop_valid", 32'(rdValid2), 0);
    checkOutput("empty_pop_hold", 32'(rdData2), 'h44);
    checkOutput("empty_pop_dc", 32'(rdDc2), 1);
    frameEnd(2);

    // Asynchronous reset clears everything before any clock edge
    rst = 1'b1;
    #2;
    checkOutput("rst2_ovf", 32'(ovf2), 0);
    checkOutput("rst2_empty", 32'(empty2), 1);
    checkOutput("rst2_data", 32'(rdData2), 0);
    tick(1);
    rst = 1'b0;
    tick(4);

    // Full FIFO, push coinciding with pop, three passes around the pointers
    frameStart(2);
    model.delete();
    for (int i = 0; i < 4; i++) begin
      w = 8'hA0 + 8'(i);
      applyStimulus(2, w, 1'(i % 2), 8, 1'b0);
      model.push_back({1'(i % 2), w});
    end
    checkOutput("wrap_full", 32'(full2), 1);
    for (int k = 0; k < 12; k++) begin
      w   = 8'hB0 + 8'(k);
      dcb = 1'(k % 3 == 0);
      applyStimulus(2, w, dcb, 7, 1'b0);
      sda = w[0]; dc = dcb;
      tick(4);
      sck[2] = 1'b1;
      tick(3);
      rdEn[2] = 1'b1;
      tick(1);
      rdEn[2] = 1'b0;
      expWord = model.pop_front();
      model.push_back({dcb, w});
      checkOutput("wrap_data", 32'(rdData2), 32'(expWord[7:0]));
      checkOutput("wrap_dc", 32'(rdDc2), 32'(expWord[8]));
      checkOutput("wrap_valid", 32'(rdValid2), 1);
      checkOutput("wrap_level", 32'(level2), 4);
      checkOutput("wrap_ovf", 32'(ovf2), 0);
      sck[2] = 1'b0;
      tick(4);
    end
`ifdef SPI_RX_OVERFLOW_COUNT_EN
    checkOutput("wrap_ovf_count", 32'(ovfCnt2), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      popWord(2);
      expWord = model.pop_front();
      checkOutput("wrap_drain_data", 32'(rdData2), 32'(expWord[7:0]));
      checkOutput("wrap_drain_dc", 32'(rdDc2), 32'(expWord[8]));
    end
    tick(1);
    checkOutput("wrap_drain_empty", 32'(empty2), 1);
    frameEnd(2);

    // Reset mid-word; reception waits for a fresh cs_n falling edge
    frameStart(0);
    applyStimulus(0, 8'hF0, 1'b1, 4, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("midrst_level", 32'(level0), 0);
    checkOutput("midrst_empty", 32'(empty0), 1);
    checkOutput("midrst_full", 32'(full0), 0);
    checkOutput("midrst_afull", 32'(afull0), 0);
    checkOutput("midrst_ovf", 32'(ovf0), 0);
    checkOutput("midrst_valid", 32'(rdValid0), 0);
    checkOutput("midrst_data", 32'(rdData0), 0);
    checkOutput("midrst_dc", 32'(rdDc0), 0);
    tick(1);
    rst = 1'b0;
    tick(4);
    applyStimulus(0, 8'hC3, 1'b1, 8, 1'b0);
    tick(2);
    checkOutput("midrst_no_rx", 32'(level0), 0);
    frameEnd(0);
    frameStart(0);
    applyStimulus(0, 8'h69, 1'b1, 8, 1'b0);
    tick(1);
    checkOutput("midrst_rx_level", 32'(level0), 1);
    popWord(0);
    checkOutput("midrst_rx_data", 32'(rdData0), 'h69);
    checkOutput("midrst_rx_dc", 32'(rdDc0), 1);
    frameEnd(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
